// File: rtl/riscv_pkg.sv
// Shared front-end definitions: NOP encoding, fetch FSM states, PC step.
package riscv_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Byte distance between consecutive instruction words.
  localparam int unsigned PC_INCR = 4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and full/empty flags.
// DEPTH must be a power of two so the pointers wrap on their own.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_data_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  output logic [WIDTH-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Next pointer/count values; flush returns everything to empty.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction-fetch front end: PC sequencing, credit-limited in-order
// memory requests, prefetch FIFO towards decode, redirect/flush handling.
module ifetch_buffer #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned            FIFO_DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready
);

  import riscv_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         discard_q, discard_d;
  logic [CW-1:0]         pending;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] fifo_head;
  logic                  fifo_push, fifo_pop;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic                  req_fire;

  // Responses return in order, so the oldest outstanding request sits
  // outstanding_q words behind the current PC.
  assign rsp_pc    = pc_q - ADDR_WIDTH'(outstanding_q) * ADDR_WIDTH'(PC_INCR);
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign fifo_push = imem_rsp_valid && (state_q == S_FETCH) && !redirect_valid;
  assign fifo_pop  = instr_valid && instr_ready && !redirect_valid;
  assign pending   = outstanding_q - CW'(imem_rsp_valid);

  sync_fifo #(
    .WIDTH (DATA_WIDTH + ADDR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i ({imem_rsp_data, rsp_pc}),
    .pop_i       (fifo_pop),
    .flush_i     (redirect_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? fifo_head[DATA_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH] : NOP_INSTR;
  assign instr_pc    = instr_valid ? fifo_head[ADDR_WIDTH-1:0] : '0;

  // State register: FSM state, PC and the two in-flight counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Next-state logic; a redirect overrides whatever the current state would do.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect_valid) begin
      // Everything still in flight is stale, including old flush victims.
      pc_d          = redirect_pc & ~ADDR_WIDTH'(3);
      outstanding_d = pending;
      discard_d     = pending;
      state_d       = (pending != '0) ? S_FLUSH : S_FETCH;
    end else begin
      unique case (state_q)
        S_BOOT: state_d = S_FETCH;
        S_FETCH: begin
          if (req_fire) pc_d = pc_q + ADDR_WIDTH'(PC_INCR);
          outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        end
        S_FLUSH: begin
          if (imem_rsp_valid) begin
            outstanding_d = outstanding_q - CW'(1);
            discard_d     = discard_q - CW'(1);
          end
          if (discard_q == '0) state_d = S_FETCH;
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  // Request outputs: issue only while credits remain and no redirect is pending.
  always_comb begin
    imem_req_valid = 1'b0;
    imem_req_addr  = pc_q;
    if (state_q == S_FETCH) begin
      imem_req_valid = (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH))
                       && !redirect_valid;
    end
  end

  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, outstanding_q} + {1'b0, fifo_count}) <= (CW+1)'(FIFO_DEPTH));
  a_rsp_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding_q != '0));
  a_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_push |-> (!fifo_full || fifo_pop));
  a_discard_bound: assert property (@(posedge clk) disable iff (!rst_n)
    discard_q <= outstanding_q);
  a_req_fire_credit: assert property (@(posedge clk) disable iff (!rst_n)
    req_fire |-> (outstanding_q != CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ifetch_buffer.sv
// Randomized bench for ifetch_buffer. A transaction-level model (epoch-tagged
// memory queue plus an expected-instruction queue) predicts every request
// address and every word handed to decode. A second instance with a
// near-top RESET_PC runs zero-wait to cover PC wrap.
module tb_ifetch_buffer;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RST_PC_A = 32'h0000_0000;
  localparam logic [31:0] RST_PC_B = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] W_SLT    = 32'h0020_A1B3;  // slt x3,x1,x2
  localparam logic [31:0] W_ADD    = 32'h0020_81B3;  // add x3,x1,x2
  localparam logic [31:0] W_DIV    = 32'h0220_C1B3;  // div x3,x1,x2

  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance A: randomized memory, decode and redirects.
  logic        a_req_valid, a_req_ready, a_rsp_valid, a_redir_valid;
  logic        a_instr_valid, a_instr_ready;
  logic [31:0] a_req_addr, a_rsp_data, a_redir_pc, a_instr, a_instr_pc;
  // Instance B: zero-wait memory, always-ready decode.
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_redir_valid;
  logic        b_instr_valid, b_instr_ready;
  logic [31:0] b_req_addr, b_rsp_data, b_redir_pc, b_instr, b_instr_pc;

  ifetch_buffer #(.RESET_PC(RST_PC_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(a_req_valid), .imem_req_ready(a_req_ready), .imem_req_addr(a_req_addr),
    .imem_rsp_valid(a_rsp_valid), .imem_rsp_data(a_rsp_data),
    .redirect_valid(a_redir_valid), .redirect_pc(a_redir_pc),
    .instr(a_instr), .instr_pc(a_instr_pc), .instr_valid(a_instr_valid),
    .instr_ready(a_instr_ready)
  );

  ifetch_buffer #(.RESET_PC(RST_PC_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_req_addr(b_req_addr),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
    .redirect_valid(b_redir_valid), .redirect_pc(b_redir_pc),
    .instr(b_instr), .instr_pc(b_instr_pc), .instr_valid(b_instr_valid),
    .instr_ready(b_instr_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state.
  mreq_t       mem_q[$];
  ent_t        exp_q[$];
  logic [31:0] model_pc;
  int          epoch, cyc, since_rst;
  logic [31:0] b_q[$];
  logic [31:0] b_pc, b_pend_addr;
  bit          b_pend, boot_chk, force_two, force_rsp, expect_req;
  int          lat_lo, lat_hi, ready_pct, ir_pct, redir_pct;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory contents repeat SLT, ADD, DIV by word index.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    k = (a >> 2) % 32'd3;
    case (k)
      32'd0:   return W_SLT;
      32'd1:   return W_ADD;
      default: return W_DIV;
    endcase
  endfunction

  function automatic bit roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // One clock cycle: drive at negedge, check settled outputs, advance model.
  task automatic step();
    bit rsp_a, redir, hs, pop, rsp_b, forced_rsp;
    logic [31:0] tgt;
    mreq_t m;
    ent_t  e;
    @(negedge clk);
    cyc++;
    since_rst++;
    forced_rsp = 1'b0;
    rsp_a = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    a_rsp_valid   = rsp_a;
    a_rsp_data    = rsp_a ? mem_word(mem_q[0].addr) : $urandom();
    a_req_ready   = roll(ready_pct);
    a_instr_ready = roll(ir_pct);
    redir = roll(redir_pct);
    tgt   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom();
    if (force_two && mem_q.size() == 2 && !rsp_a) begin
      redir = 1'b1; tgt = 32'h0000_0103; force_two = 1'b0;
    end
    if (force_rsp && mem_q.size() == 1 && rsp_a) begin
      redir = 1'b1; force_rsp = 1'b0; forced_rsp = 1'b1;
    end
    a_redir_valid = redir;
    a_redir_pc    = tgt;
    rsp_b = b_pend;
    b_rsp_valid = rsp_b;
    b_rsp_data  = rsp_b ? mem_word(b_pend_addr) : 32'h0;
    #1;

    // Instance A checks.
    if (expect_req) begin
      check("no_flush_req", a_req_valid, 1'b1);
      expect_req = 1'b0;
    end
    if (boot_chk && since_rst <= 3) begin
      check("boot_valid_a", a_instr_valid, since_rst == 3);
      check("boot_valid_b", b_instr_valid, since_rst == 3);
      if (since_rst == 3) boot_chk = 1'b0;
    end
    check("instr_valid", a_instr_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("instr", a_instr, exp_q[0].data);
      check("instr_pc", a_instr_pc, exp_q[0].pc);
    end else begin
      check("instr_nop", a_instr, NOP);
      check("instr_pc_empty", a_instr_pc, 32'h0);
    end
    hs = a_req_valid && a_req_ready;
    if (redir) check("req_on_redirect", a_req_valid, 1'b0);
    if (a_req_valid) check("req_credit", (mem_q.size() + exp_q.size()) < DEPTH, 1'b1);
    if (hs) check("req_addr", a_req_addr, model_pc);

    // Instance A model update.
    pop = (exp_q.size() != 0) && a_instr_ready;
    if (redir) begin
      exp_q.delete();
      if (rsp_a) void'(mem_q.pop_front());
      epoch++;
      model_pc = {tgt[31:2], 2'b00};
      if (forced_rsp) expect_req = 1'b1;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (rsp_a) begin
        m = mem_q.pop_front();
        if (m.epoch == epoch) begin
          e.data = mem_word(m.addr);
          e.pc   = m.addr;
          exp_q.push_back(e);
        end
      end
      if (hs) begin
        m.addr  = model_pc;
        m.epoch = epoch;
        m.due   = cyc + int'($urandom_range(lat_hi, lat_lo));
        mem_q.push_back(m);
        model_pc += 32'd4;
      end
    end

    // Instance B checks and model.
    check("b_valid", b_instr_valid, b_q.size() != 0);
    if (b_q.size() != 0) begin
      check("b_instr_pc", b_instr_pc, b_q[0]);
      check("b_instr", b_instr, mem_word(b_q[0]));
      void'(b_q.pop_front());
    end
    if (b_req_valid) check("b_req_addr", b_req_addr, b_pc);
    if (rsp_b) b_q.push_back(b_pend_addr);
    b_pend      = b_req_valid;
    b_pend_addr = b_pc;
    if (b_req_valid) b_pc += 32'd4;
  endtask

  task automatic idle_inputs();
    a_rsp_valid = 1'b0; a_redir_valid = 1'b0; a_req_ready = 1'b0; a_instr_ready = 1'b0;
    b_rsp_valid = 1'b0;
  endtask

  // Asynchronous reset asserted between clock edges; outputs checked before any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_req_valid", a_req_valid, 1'b0);
    check("rst_req_addr", a_req_addr, RST_PC_A);
    check("rst_instr_valid", a_instr_valid, 1'b0);
    check("rst_instr", a_instr, NOP);
    check("rst_instr_pc", a_instr_pc, 32'h0);
    check("rst_b_req_addr", b_req_addr, RST_PC_B);
    check("rst_b_req_valid", b_req_valid, 1'b0);
    mem_q.delete();
    exp_q.delete();
    b_q.delete();
    b_pend   = 1'b0;
    model_pc = RST_PC_A;
    b_pc     = RST_PC_B;
    epoch++;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    since_rst = 0;
    boot_chk  = 1'b1;
  endtask

  task automatic knobs(input int lo, input int hi, input int rdy, input int ir, input int rd);
    lat_lo = lo; lat_hi = hi; ready_pct = rdy; ir_pct = ir; redir_pct = rd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    a_rsp_data = '0; a_redir_pc = '0;
    b_req_ready = 1'b1; b_instr_ready = 1'b1; b_redir_valid = 1'b0; b_redir_pc = '0;
    b_rsp_data = '0;
    epoch = 0; cyc = 0; since_rst = 0;
    force_two = 1'b0; force_rsp = 1'b0; expect_req = 1'b0; boot_chk = 1'b0;
    knobs(1, 1, 100, 100, 0);
    @(negedge clk);
    do_reset();

    // Zero-wait streaming.
    repeat (20) step();

    // Decode stalled: FIFO fills, requests stop, then drain in order.
    ir_pct = 0;
    repeat (10) step();
    check("stall_valid", a_instr_valid, 1'b1);
    check("stall_no_req", a_req_valid, 1'b0);
    ir_pct = 100;
    repeat (10) step();

    // Redirect to 0x103 with two requests in flight (latency 3).
    knobs(3, 3, 100, 100, 0);
    force_two = 1'b1;
    for (int i = 0; i < 50 && force_two; i++) step();
    check("force_two_hit", force_two, 1'b0);
    repeat (20) step();

    // Redirect coinciding with the only outstanding response.
    knobs(2, 2, 100, 100, 0);
    force_rsp = 1'b1;
    for (int i = 0; i < 50 && force_rsp; i++) step();
    check("force_rsp_hit", force_rsp, 1'b0);
    repeat (10) step();

    // Random traffic with redirects.
    knobs(1, 4, 70, 60, 5);
    repeat (3000) step();

    // Reset in the middle of a flush with two stale requests.
    knobs(4, 4, 100, 100, 0);
    force_two = 1'b1;
    for (int i = 0; i < 50 && force_two; i++) step();
    check("force_flush_hit", force_two, 1'b0);
    step();
    check("flush_no_req", a_req_valid, 1'b0);
    knobs(1, 1, 100, 100, 0);
    do_reset();
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_buffer.md
Name: ifetch_buffer

Overview:
- Instruction-fetch front end that produces the `instr` word consumed by the decoder.
- Maintains the PC and issues in-order word requests to instruction memory.
- Buffers returned words in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Honours redirects from branch/jump resolution by flushing the FIFO and discarding in-flight responses.

Parameters:
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, PC / memory address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, prefetch entries; power of two, >= 2
- NOP_INSTR, 32'h0000_0013, word driven on `instr` when no valid instruction (addi x0,x0,0)

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  ADDR_WIDTH  word-aligned fetch address
- imem_rsp_valid  input  1  response valid; in order, no backpressure
- imem_rsp_data  input  DATA_WIDTH  fetched word
- redirect_valid  input  1  one-cycle pulse, change PC
- redirect_pc  input  ADDR_WIDTH  new PC; bits [1:0] ignored, forced 0
- instr  output  DATA_WIDTH  to decoder `instr`; FIFO head, or NOP_INSTR when empty
- instr_pc  output  ADDR_WIDTH  PC of `instr`; 0 when empty
- instr_valid  output  1  FIFO non-empty
- instr_ready  input  1  decode consumes head this cycle

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=S_BOOT.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=NOP_INSTR, instr_pc=0.
- FSM S_BOOT: no request; unconditionally to S_FETCH next cycle.
- FSM S_FETCH:
  - imem_req_valid = (outstanding + fifo_count < FIFO_DEPTH) && !redirect_valid.
  - imem_req_addr = pc.
  - On request handshake: pc <= pc+4 (wraps mod 2^ADDR_WIDTH), outstanding++.
- FSM S_FLUSH:
  - imem_req_valid=0; every response decrements discard and outstanding; data dropped.
  - Exit to S_FETCH the cycle after discard reaches 0.
- Credit rule: outstanding + fifo_count <= FIFO_DEPTH at all times, so a response always has a free slot. A response arriving with the FIFO full is a protocol error; assertion only.
- Response in S_FETCH:
  - Push {data, pc_of_request} into FIFO; outstanding--.
  - Request PCs are tracked by a small PC-tag FIFO, or recomputed as pc - 4*outstanding.
- Latency: response at cycle N -> instr_valid=1 at N+1. No combinational bypass from imem_rsp to instr.
- Pop: instr_valid && instr_ready. Simultaneous push and pop is allowed, count unchanged, including when full.
- Redirect (any state):
  - FIFO cleared; pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}; no request issued that cycle.
  - Let pending = outstanding minus any response arriving that same cycle (that response is dropped).
  - If pending > 0: discard <= pending, outstanding <= pending, go to S_FLUSH.
  - Otherwise go to S_FETCH.
- Redirect during S_FLUSH: pc updated; discard continues counting the old requests.
- Redirect and instr_ready in the same cycle: the flush wins; the pop is irrelevant.
- Redirect in S_BOOT: pc updated; still to S_FETCH.
- instr_valid drops to 0 the cycle after a redirect.
- PC wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
- Counters are sized $clog2(FIFO_DEPTH+1) and never over- or underflow; checked by assertions.

Decomposition:
- Shared package `riscv_pkg`:
  - NOP_INSTR constant.
  - fetch state enum {S_BOOT, S_FETCH, S_FLUSH}.
  - PC increment constant 4.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/flush/count/full/empty).
  - Instantiated once with WIDTH=DATA_WIDTH+ADDR_WIDTH.
  - Reused elsewhere in the pipeline.

Test Plan:
- Reset then zero-wait memory (ready=1, rsp 1 cycle later) with instr_ready=1 -> requests at 0x0, 0x4, 0x8...; instr_valid first high cycle 3 after release; instr_pc sequence 0x0, 0x4, 0x8.
- Response data = SLT, then ADD, then DIV encodings; decode stalled (instr_ready=0) -> FIFO fills to 2, imem_req_valid=0 with outstanding=0. Release ready -> words popped in order SLT, ADD, DIV, no loss or duplicate.
- Two requests outstanding (memory latency 3), redirect_pc=0x0000_0103 -> pc becomes 0x100, S_FLUSH; both stale responses dropped; first new request addr 0x100; first instr_pc=0x100.
- Redirect in the same cycle as a response, with 1 outstanding -> that response dropped, no S_FLUSH entry, next request addr=redirect target.
- RESET_PC=32'hFFFF_FFF8 -> request addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst_n asserted mid-flush with 2 outstanding -> all outputs return to reset values asynchronously; after release, first request addr=RESET_PC, and late stale responses are ignored by the bench model.
